// File: rtl/pwm_motion_sequencer_pkg.sv
// Shared definitions for the per-axis PWM motion sequencer: state encoding and
// clock-derived parameter defaults.
package pwm_motion_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_BRAKE    = 3'd2,
    ST_DEADTIME = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  localparam int CLK_FREQ         = 12_000_000;
  localparam int COUNTER_W_DEF    = 12;
  localparam int RAMP_DIV_DEF     = CLK_FREQ / 10_000;  // 100 us
  localparam int DEADTIME_CYC_DEF = CLK_FREQ / 10_000;  // 100 us
  localparam int WDT_CYC_DEF      = CLK_FREQ / 10;      // 100 ms

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_motion_sequencer_ramp_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks; shared by
// the pitch and yaw sequencers.
module ramp_tick_gen
  import pwm_motion_sequencer_pkg::*;
#(
  parameter int DIV = RAMP_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int D = (DIV < 1) ? 1 : DIV;
  localparam int W = cnt_width(D);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || cnt == W'(D - 1)) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(D - 1));

endmodule

// File: rtl/pwm_motion_sequencer.sv
// Per-axis controller between SPI setpoint registers and one PWM: slew-limited
// duty ramp, brake/dead-time on direction reversal, and a command watchdog.
module pwm_motion_sequencer
  import pwm_motion_sequencer_pkg::*;
#(
  parameter int COUNTER_W    = COUNTER_W_DEF,
  parameter int RAMP_DIV     = RAMP_DIV_DEF,
  parameter int RAMP_STEP    = 16,
  parameter int DEADTIME_CYC = DEADTIME_CYC_DEF,
  parameter int WDT_CYC      = WDT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_enable,
  input  logic                 cmd_direction,
  input  logic [COUNTER_W-1:0] cmd_duty,
  output logic                 pwm_enable,
  output logic                 pwm_direction,
  output logic [COUNTER_W-1:0] pwm_duty,
  output logic                 busy,
  output logic                 fault
);

  localparam int DT_CYC = (DEADTIME_CYC < 1) ? 1 : DEADTIME_CYC;
  localparam int DT_W   = cnt_width(DT_CYC);
  localparam int WDT_W  = cnt_width(WDT_CYC);
  localparam logic        [COUNTER_W-1:0] STEP_U = COUNTER_W'(RAMP_STEP);
  localparam logic signed [COUNTER_W:0]   STEP_S = $signed({1'b0, STEP_U});

  // One bit of headroom keeps the difference exact, so a step never wraps.
  function automatic logic [COUNTER_W-1:0] ramp_to(input logic [COUNTER_W-1:0] cur,
                                                   input logic [COUNTER_W-1:0] tgt);
    logic signed [COUNTER_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       ramp_to = cur + STEP_U;
    else if (diff < -STEP_S) ramp_to = cur - STEP_U;
    else                     ramp_to = tgt;
  endfunction

  logic                 tick;
  logic                 vld_p0, en_p0, dir_p0;
  logic [COUNTER_W-1:0] duty_p0;
  logic                 tgt_en, tgt_dir;
  logic [COUNTER_W-1:0] tgt_duty;
  state_e               state, state_n;
  logic                 en_n, dir_n, busy_n, fault_n;
  logic [COUNTER_W-1:0] duty_n;
  logic [DT_W-1:0]      dead_cnt, dead_n;
  logic [WDT_W-1:0]     wdt_cnt;
  logic                 wdt_active, wdt_expire;

  ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0: capture the SPI write strobe and its setpoint.
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= cmd_valid;
  end

  always_ff @(posedge clk) begin
    en_p0   <= cmd_enable;
    dir_p0  <= cmd_direction;
    duty_p0 <= cmd_duty;
  end

  // Stage p1: target registers; an enable request while faulted is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_en   <= 1'b0;
      tgt_dir  <= 1'b0;
      tgt_duty <= '0;
    end else if (vld_p0 && !(state == ST_FAULT && en_p0)) begin
      tgt_en   <= en_p0;
      tgt_dir  <= dir_p0;
      tgt_duty <= duty_p0;
    end
  end

  assign wdt_active = (state != ST_IDLE) && (state != ST_FAULT);
  assign wdt_expire = (WDT_CYC > 0) && wdt_active && !cmd_valid &&
                      (wdt_cnt == WDT_W'(WDT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || cmd_valid || !wdt_active) wdt_cnt <= '0;
    else                                   wdt_cnt <= wdt_cnt + 1'b1;
  end

  // Stage p2: sequencing FSM; every output is computed here and registered.
  always_comb begin
    state_n = state;
    en_n    = pwm_enable;
    dir_n   = pwm_direction;
    duty_n  = pwm_duty;
    dead_n  = dead_cnt;
    case (state)
      ST_IDLE: begin
        en_n   = 1'b0;
        duty_n = '0;
        if (tgt_en) begin
          state_n = ST_RUN;
          en_n    = 1'b1;
          dir_n   = tgt_dir;
        end
      end
      ST_RUN: begin
        en_n = 1'b1;
        if (!tgt_en || tgt_dir != pwm_direction) state_n = ST_BRAKE;
        else if (tick)                           duty_n  = ramp_to(pwm_duty, tgt_duty);
      end
      ST_BRAKE: begin
        en_n = 1'b1;
        if (tgt_en && tgt_dir == pwm_direction) begin
          state_n = ST_RUN;
        end else if (pwm_duty == '0) begin
          state_n = ST_DEADTIME;
          en_n    = 1'b0;
          dead_n  = '0;
        end else if (tick) begin
          duty_n = ramp_to(pwm_duty, {COUNTER_W{1'b0}});
        end
      end
      ST_DEADTIME: begin
        en_n   = 1'b0;
        duty_n = '0;
        if (dead_cnt == DT_W'(DT_CYC - 1)) begin
          if (tgt_en) begin
            state_n = ST_RUN;
            en_n    = 1'b1;
            dir_n   = tgt_dir;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          dead_n = dead_cnt + 1'b1;
        end
      end
      ST_FAULT: begin
        en_n   = 1'b0;
        duty_n = '0;
        if (vld_p0 && !en_p0) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        en_n    = 1'b0;
        duty_n  = '0;
      end
    endcase
    if (wdt_expire) begin
      state_n = ST_FAULT;
      en_n    = 1'b0;
      duty_n  = '0;
    end
    busy_n  = (state_n == ST_BRAKE) || (state_n == ST_DEADTIME) ||
              ((state_n == ST_RUN) && (duty_n != tgt_duty));
    fault_n = (state_n == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pwm_enable    <= 1'b0;
      pwm_direction <= 1'b0;
      pwm_duty      <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      dead_cnt      <= '0;
    end else begin
      state         <= state_n;
      pwm_enable    <= en_n;
      pwm_direction <= dir_n;
      pwm_duty      <= duty_n;
      busy          <= busy_n;
      fault         <= fault_n;
      dead_cnt      <= dead_n;
    end
  end

endmodule

// File: tb/tb_pwm_motion_sequencer.sv
// Scoreboard bench for pwm_motion_sequencer: each output change is matched
// against a queue of hand-computed {enable,direction,duty,busy,fault} tuples.
module tb_pwm_motion_sequencer;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_enable = 1'b0;
  logic          cmd_direction = 1'b0;
  logic [CW-1:0] cmd_duty = '0;
  logic          pwm_enable, pwm_direction, busy, fault;
  logic [CW-1:0] pwm_duty;

  pwm_motion_sequencer #(
    .COUNTER_W    (CW),
    .RAMP_DIV     (4),
    .RAMP_STEP    (100),
    .DEADTIME_CYC (8),
    .WDT_CYC      (1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_enable    (cmd_enable),
    .cmd_direction (cmd_direction),
    .cmd_duty      (cmd_duty),
    .pwm_enable    (pwm_enable),
    .pwm_direction (pwm_direction),
    .pwm_duty      (pwm_duty),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          kick_cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] prev, mon_obs, mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mk(input bit en, input bit dir, input int duty,
                                     input bit bz, input bit flt);
    logic [CW-1:0] d;
    d = duty[CW-1:0];
    return {en, dir, d, bz, flt};
  endfunction

  function automatic logic [15:0] cur();
    return {pwm_enable, pwm_direction, pwm_duty, busy, fault};
  endfunction

  task automatic show(input string name, input logic [15:0] got, input logic [15:0] want);
    $display("FAIL %s: got en=%0d dir=%0d duty=%0d busy=%0d fault=%0d, want en=%0d dir=%0d duty=%0d busy=%0d fault=%0d",
             name, got[15], got[14], got[13:2], got[1], got[0],
             want[15], want[14], want[13:2], want[1], want[0]);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      show(name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push(input bit en, input bit dir, input int duty, input bit bz, input bit flt);
    exp_q.push_back(mk(en, dir, duty, bz, flt));
  endtask

  // Called at a negedge; cmd_valid is sampled on the following posedge.
  task automatic send(input bit en, input bit dir, input int duty);
    cmd_enable    = en;
    cmd_direction = dir;
    cmd_duty      = duty[CW-1:0];
    cmd_valid     = 1'b1;
    @(posedge clk);
    #1 kick_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d expected changes still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_duty(input int value, input int budget);
    int n;
    n = 0;
    while (pwm_duty != value[CW-1:0] && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_obs = cur();
      if (mon_obs !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          show("unexpected_change(want=previous)", mon_obs, prev);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp) begin
            bad++;
            show("output_sequence", mon_obs, mon_exp);
          end
        end
        prev = mon_obs;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int dt;
    repeat (3) @(negedge clk);
    chk("reset_state", cur(), mk(0, 0, 0, 0, 0));
    reset = 1'b0;
    prev = cur();
    mon_en = 1'b1;
    @(negedge clk);

    // Ramp up from IDLE, with first-change latency.
    push(1, 0, 0, 1, 0);
    push(1, 0, 100, 1, 0);
    push(1, 0, 200, 1, 0);
    push(1, 0, 250, 0, 0);
    send(1, 0, 250);
    @(posedge clk);
    #1 chk_int("enable_at_n1", int'(pwm_enable), 0);
    @(posedge clk);
    #1 chk_int("enable_at_n2", int'(pwm_enable), 1);
    @(negedge clk);
    wait_drain(100, "ramp_up");

    // Reversal aborted at 150: back to RUN with no dead-time.
    push(1, 0, 250, 1, 0);
    push(1, 0, 150, 1, 0);
    push(1, 0, 250, 0, 0);
    send(1, 1, 300);
    wait_duty(150, 100);
    send(1, 0, 250);
    wait_drain(100, "brake_abort");

    // Full reversal through dead-time.
    push(1, 0, 250, 1, 0);
    push(1, 0, 150, 1, 0);
    push(1, 0, 50, 1, 0);
    push(1, 0, 0, 1, 0);
    push(0, 0, 0, 1, 0);
    push(1, 1, 0, 1, 0);
    push(1, 1, 100, 1, 0);
    push(1, 1, 200, 1, 0);
    push(1, 1, 300, 0, 0);
    send(1, 1, 300);
    n = 0;
    while (pwm_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    dt = 0;
    while (!pwm_enable && dt < 100) begin
      dt++;
      @(negedge clk);
    end
    chk_int("deadtime_cycles", dt, 8);
    wait_drain(200, "reversal");

    // Watchdog trips 1000 cycles after the last command.
    push(0, 1, 0, 0, 1);
    n = 0;
    while (!fault && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk_int("wdt_trip_cycles", cyc - kick_cyc, 1000);
    send(1, 0, 100);
    repeat (20) @(negedge clk);
    chk("fault_ignores_enable", cur(), mk(0, 1, 0, 0, 1));
    push(0, 1, 0, 0, 0);
    send(0, 0, 0);
    wait_drain(20, "fault_clear");

    // Ramp to full scale, last step clamps to 4095.
    push(1, 0, 0, 1, 0);
    for (int k = 1; k <= 40; k++) push(1, 0, 100 * k, 1, 0);
    push(1, 0, 4095, 0, 0);
    send(1, 0, 4095);
    wait_drain(400, "full_scale");

    // Kick lands exactly on the expiry cycle.
    n = 0;
    while (cyc != kick_cyc + 999 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    send(1, 0, 4095);
    repeat (20) @(negedge clk);
    chk("kick_on_expiry", cur(), mk(1, 0, 4095, 0, 0));

    // Reset while running, then reset mid-ramp at 200.
    push(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_from_run", cur(), mk(0, 0, 0, 0, 0));
    push(1, 1, 0, 1, 0);
    push(1, 1, 100, 1, 0);
    push(1, 1, 200, 1, 0);
    send(1, 1, 500);
    wait_duty(200, 100);
    push(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_mid_ramp", cur(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    wait_drain(20, "reset_mid_ramp_seq");
    repeat (10) @(negedge clk);
    chk("idle_after_reset", cur(), mk(0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
